// File: rtl/cpu_core.sv
// rtl/cpu_core.sv - NoC traffic CPU endpoint: sends sequence-tagged words, counts responses.
// Optional CPU_RX_CHECK_EN enables in-order checking of inbound sequence numbers.
module cpu_core #(
    parameter logic [31:0] NUM_TRANSACTIONS = 32'd16,
    parameter logic [31:0] SEND_GAP         = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_index,
    input  logic        data_cpu_to_noc_rdy,
    output logic        data_cpu_to_noc_vld,
    output logic [63:0] data_cpu_to_noc,
    output logic        data_noc_to_cpu_rdy,
    input  logic        data_noc_to_cpu_vld,
    input  logic [63:0] data_noc_to_cpu,
    output logic        transactions_done,
    output logic [15:0] error_count
);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] tx_seq_q, tx_seq_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic [31:0] rx_count_q, rx_count_d;
    logic        vld_q, vld_d;
    logic [63:0] data_q, data_d;
    logic        rdy_q, rdy_d;
    logic        done_q, done_d;
    logic [15:0] err_q, err_d;
    logic        tx_accept;
    logic        rx_accept;
    logic        unused_rx;

    assign tx_accept = vld_q & data_cpu_to_noc_rdy;
    assign rx_accept = rdy_q & data_noc_to_cpu_vld;
    assign unused_rx = ^data_noc_to_cpu;

    always_comb begin
        state_d   = state_q;
        tx_seq_d  = tx_seq_q;
        gap_cnt_d = gap_cnt_q;
        vld_d     = vld_q;
        data_d    = data_q;
        case (state_q)
            IDLE: begin
                if (NUM_TRANSACTIONS != 32'd0) begin
                    state_d  = SEND;
                    vld_d    = 1'b1;
                    tx_seq_d = 32'd0;
                    data_d   = {cpu_index, 32'd0};
                end else begin
                    state_d = DONE;
                end
            end
            SEND: begin
                if (tx_accept) begin
                    tx_seq_d = tx_seq_q + 32'd1;
                    if (tx_seq_q + 32'd1 == NUM_TRANSACTIONS) begin
                        state_d = DONE;
                        vld_d   = 1'b0;
                    end else if (SEND_GAP != 32'd0) begin
                        state_d   = GAP;
                        vld_d     = 1'b0;
                        gap_cnt_d = 32'd0;
                    end else begin
                        data_d = {cpu_index, tx_seq_q + 32'd1};
                    end
                end
            end
            GAP: begin
                // tx_seq already points at the next word to send
                if (gap_cnt_q == SEND_GAP - 32'd1) begin
                    state_d = SEND;
                    vld_d   = 1'b1;
                    data_d  = {cpu_index, tx_seq_q};
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
            DONE: begin
                vld_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        rx_count_d = rx_count_q + {31'd0, rx_accept};
        // Look ahead at the post-accept count so an extra word is never taken
        rdy_d      = (rx_count_d < NUM_TRANSACTIONS);
        done_d     = done_q | ((state_q == DONE) && (rx_count_q == NUM_TRANSACTIONS));
        err_d      = err_q;
`ifdef CPU_RX_CHECK_EN
        if (rx_accept && (data_noc_to_cpu[31:0] != rx_count_q) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
`else
        err_d = 16'd0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_seq_q   <= 32'd0;
            gap_cnt_q  <= 32'd0;
            rx_count_q <= 32'd0;
            vld_q      <= 1'b0;
            data_q     <= 64'd0;
            rdy_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            tx_seq_q   <= tx_seq_d;
            gap_cnt_q  <= gap_cnt_d;
            rx_count_q <= rx_count_d;
            vld_q      <= vld_d;
            data_q     <= data_d;
            rdy_q      <= rdy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign data_cpu_to_noc_vld = vld_q;
    assign data_cpu_to_noc     = data_q;
    assign data_noc_to_cpu_rdy = rdy_q;
    assign transactions_done   = done_q;
    assign error_count         = err_q;

endmodule

// File: tb/tb_cpu_core.sv
// tb/tb_cpu_core.sv - randomized self-checking bench for cpu_core against a counting model.
module tb_cpu_core;

    localparam logic [31:0] N0 = 32'd4, N1 = 32'd5, N2 = 32'd0;
    localparam logic [31:0] G0 = 32'd0, G1 = 32'd2, G2 = 32'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_idx  [3];
    logic        tx_rdy   [3];
    logic        tx_vld   [3];
    logic [63:0] tx_data  [3];
    logic        rx_rdy   [3];
    logic        rx_vld   [3];
    logic [63:0] rx_data  [3];
    logic        done_o   [3];
    logic [15:0] err_o    [3];

    int unsigned nt [3];
    int unsigned gp [3];
    int unsigned sent [3], rxc [3], gapl [3], errc [3];
    bit          mdone [3];
    bit          started;
    int          tests = 0;
    int          fails = 0;
    int          mode  = 0;

    always #5 clk = ~clk;

    cpu_core #(.NUM_TRANSACTIONS(N0), .SEND_GAP(G0)) u0 (
        .clk(clk), .rst(rst), .cpu_index(cpu_idx[0]),
        .data_cpu_to_noc_rdy(tx_rdy[0]), .data_cpu_to_noc_vld(tx_vld[0]), .data_cpu_to_noc(tx_data[0]),
        .data_noc_to_cpu_rdy(rx_rdy[0]), .data_noc_to_cpu_vld(rx_vld[0]), .data_noc_to_cpu(rx_data[0]),
        .transactions_done(done_o[0]), .error_count(err_o[0]));

    cpu_core #(.NUM_TRANSACTIONS(N1), .SEND_GAP(G1)) u1 (
        .clk(clk), .rst(rst), .cpu_index(cpu_idx[1]),
        .data_cpu_to_noc_rdy(tx_rdy[1]), .data_cpu_to_noc_vld(tx_vld[1]), .data_cpu_to_noc(tx_data[1]),
        .data_noc_to_cpu_rdy(rx_rdy[1]), .data_noc_to_cpu_vld(rx_vld[1]), .data_noc_to_cpu(rx_data[1]),
        .transactions_done(done_o[1]), .error_count(err_o[1]));

    cpu_core #(.NUM_TRANSACTIONS(N2), .SEND_GAP(G2)) u2 (
        .clk(clk), .rst(rst), .cpu_index(cpu_idx[2]),
        .data_cpu_to_noc_rdy(tx_rdy[2]), .data_cpu_to_noc_vld(tx_vld[2]), .data_cpu_to_noc(tx_data[2]),
        .data_noc_to_cpu_rdy(rx_rdy[2]), .data_noc_to_cpu_vld(rx_vld[2]), .data_noc_to_cpu(rx_data[2]),
        .transactions_done(done_o[2]), .error_count(err_o[2]));

    function automatic bit exp_vld(int i);
        return started && (sent[i] < nt[i]) && (gapl[i] == 0);
    endfunction

    function automatic bit exp_rdy(int i);
        return started && (rxc[i] < nt[i]);
    endfunction

    task automatic check(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, i, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            if (mode == 0) begin
                tx_rdy[i]  = 1'b1;
                rx_vld[i]  = 1'b1;
                rx_data[i] = {32'h0, rxc[i]};
            end else begin
                tx_rdy[i]  = ($urandom_range(0, 2) == 0);
                rx_vld[i]  = ($urandom_range(0, 1) == 0);
                rx_data[i] = {$urandom, ($urandom_range(0, 5) == 0) ? rxc[i] + 32'd7 : rxc[i]};
            end
        end
    endtask

    task automatic cycle();
        bit tx_acc [3];
        bit rx_acc [3];
        bit bad    [3];
        bit dset   [3];
        for (int i = 0; i < 3; i++) begin
            tx_acc[i] = !rst && exp_vld(i) && tx_rdy[i];
            rx_acc[i] = !rst && exp_rdy(i) && rx_vld[i];
            bad[i]    = rx_acc[i] && (rx_data[i][31:0] != rxc[i]);
            dset[i]   = !rst && started && (sent[i] == nt[i]) && (rxc[i] == nt[i]);
        end
        @(posedge clk);
        if (rst) begin
            started = 0;
            for (int i = 0; i < 3; i++) begin
                sent[i] = 0; rxc[i] = 0; gapl[i] = 0; errc[i] = 0; mdone[i] = 0;
            end
        end else if (!started) begin
            started = 1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (tx_acc[i]) begin
                    sent[i]++;
                    gapl[i] = gp[i];
                end else if (gapl[i] > 0) begin
                    gapl[i]--;
                end
                if (rx_acc[i]) rxc[i]++;
                if (bad[i] && errc[i] < 65535) errc[i]++;
                if (dset[i]) mdone[i] = 1;
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check("vld", i, {63'd0, tx_vld[i]}, {63'd0, exp_vld(i)});
            if (exp_vld(i))
                check("data", i, tx_data[i], {cpu_idx[i], sent[i]});
            else if (!started)
                check("data_rst", i, tx_data[i], 64'd0);
            check("rdy", i, {63'd0, rx_rdy[i]}, {63'd0, exp_rdy(i)});
            check("done", i, {63'd0, done_o[i]}, {63'd0, mdone[i]});
`ifdef CPU_RX_CHECK_EN
            check("errs", i, {48'd0, err_o[i]}, {48'd0, errc[i][15:0]});
`else
            check("errs", i, {48'd0, err_o[i]}, 64'd0);
`endif
        end
        drive();
    endtask

    initial begin
        nt[0] = N0; nt[1] = N1; nt[2] = N2;
        gp[0] = G0; gp[1] = G1; gp[2] = G2;
        cpu_idx[0] = 32'd5; cpu_idx[1] = 32'hA5A5_0001; cpu_idx[2] = 32'd7;
        started = 0;
        for (int i = 0; i < 3; i++) begin
            sent[i] = 0; rxc[i] = 0; gapl[i] = 0; errc[i] = 0; mdone[i] = 0;
        end
        mode = 0;
        drive();
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (20) cycle();

        rst = 1'b1;
        mode = 1;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (80) cycle();

        rst = 1'b1;
        mode = 0;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (4) cycle();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        mode = 1;
        repeat (80) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
# cpu_core

Traffic-generating CPU endpoint for the multi-simulation NoC example. It pushes a fixed number of sequence-tagged 64-bit transactions toward the NoC over a valid/ready channel. It accepts the same number of responses from the NoC on a second valid/ready channel and flags completion. It sits between the push client (CPU→NoC) and the pull client (NoC→CPU) in each CPU-side simulation.

## Interface
Parameters:
- NUM_TRANSACTIONS, 16: transactions to send and responses to receive (0..2^32-1).
- SEND_GAP, 0: idle cycles inserted after each accepted transaction before the next valid.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- cpu_index  input  32  identity of this CPU, static after reset.
- data_cpu_to_noc_rdy  input  1  NoC accepts outbound word.
- data_cpu_to_noc_vld  output  1  outbound word valid.
- data_cpu_to_noc  output  64  outbound word.
- data_noc_to_cpu_rdy  output  1  CPU accepts inbound word.
- data_noc_to_cpu_vld  input  1  inbound word valid.
- data_noc_to_cpu  input  64  inbound word.
- transactions_done  output  1  all sends and receives complete, sticky.
- error_count  output  16  inbound check failures (see Configuration).

## Operation
- The send FSM has states IDLE, SEND, GAP and DONE. Reset enters IDLE.
- IDLE→SEND on the first edge with rst low, if NUM_TRANSACTIONS>0. Otherwise IDLE→DONE.
- Entering SEND loads the payload {cpu_index[31:0], tx_seq[31:0]}. tx_seq starts at 0.
- In SEND, vld=1. An accept (vld&&rdy) increments tx_seq.
  - If tx_seq+1==NUM_TRANSACTIONS, the FSM goes to DONE.
  - Otherwise, if SEND_GAP>0, it goes to GAP.
  - Otherwise it stays in SEND with the next payload loaded on the same edge. Back-to-back accepts are allowed.
- GAP holds vld=0 for SEND_GAP cycles, then returns to SEND with the next payload.
- DONE holds vld=0 permanently until reset.
- Receive side: rx_count starts at 0.
  - data_noc_to_cpu_rdy is registered and high while rx_count<NUM_TRANSACTIONS (from the first edge after reset release).
  - Each accept increments rx_count.
  - rdy drops on the edge where rx_count reaches NUM_TRANSACTIONS, so an extra word is never accepted.
- transactions_done is set one edge after tx is in DONE and rx_count==NUM_TRANSACTIONS. It stays set until rst.
- Counters are 32-bit with no wrap. error_count saturates at 16'hFFFF.

## Timing
- Reset values: vld=0, data_cpu_to_noc=0, rdy=0, transactions_done=0, error_count=0, counters 0.
- All outputs are registered. The first vld and rdy rise on the first rising edge with rst low.
- Handshake: once vld=1, vld and data stay stable until accepted. The ready input may toggle freely and has no combinational path to vld.
- rdy does not depend combinationally on data_noc_to_cpu_vld.
- Send and receive are independent. Simultaneous accepts on both channels in one cycle are legal and both are counted.
- Reset mid-operation aborts everything. On the next edge after rst falls, sending restarts at tx_seq 0 and rx_count returns to 0.
- NUM_TRANSACTIONS=0:
  - vld never asserts and rdy never asserts.
  - transactions_done rises at the second edge after reset release.

## Configuration
- CPU_RX_CHECK_EN defined:
  - Each accepted inbound word must satisfy data_noc_to_cpu[31:0]==rx_count (in-order sequence).
  - Each mismatch increments error_count.
  - Checking runs regardless of the upper 32 bits.
- CPU_RX_CHECK_EN not defined:
  - No check logic is present and error_count is tied to 0.
  - Inbound data is accepted and discarded.

## Test plan
- rst for 3 cycles, cpu_index=5, N=4, CPU→NoC rdy constantly 1, SEND_GAP=0 -> words 0x00000005_00000000..0x00000005_00000003 on four consecutive cycles, then vld=0.
- rdy toggled 1-of-3 cycles on CPU→NoC -> vld/data held stable while rdy=0, no word duplicated or skipped, sequence 0..N-1.
- SEND_GAP=2, rdy=1 -> exactly 2 vld-low cycles between accepts.
- Inbound: 4 words with low half 0,1,2,3, vld=1 throughout -> rdy low after the 4th accept; transactions_done=1 one edge after both sides finish; error_count=0.
- With CPU_RX_CHECK_EN, inbound low halves 0,7,2,3 -> error_count=1. Without the macro -> error_count=0.
- Assert rst after 2 sends and 1 receive -> outputs return to reset values; after release the first word carries tx_seq 0. N=0 -> done at the 2nd edge after release, no vld.
